// File: rtl/uart_rx_byte_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_buffer_if
// Groups the non-clock signals of the UART receive byte buffer.
//   UART side : UART_DATA, UART_RXRDY (from CoreUART), UART_OEN (to CoreUART)
//   CPU side  : POP, CLR_OVF (from MMIO), POP_DATA, FIFO_COUNT, EMPTY, FULL,
//               OVERFLOW, IRQ (to processor)
// Modports:
//   slave  - the buffer itself
//   master - the surrounding system (UART + processor), e.g. a testbench
// ---------------------------------------------------------------------------
interface uart_rx_byte_buffer_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]      UART_DATA;
   logic            UART_RXRDY;
   logic            UART_OEN;
   logic            POP;
   logic [7:0]      POP_DATA;
   logic [ADDR_W:0] FIFO_COUNT;
   logic            EMPTY;
   logic            FULL;
   logic            OVERFLOW;
   logic            CLR_OVF;
   logic            IRQ;

   modport slave (
      input  UART_DATA, UART_RXRDY, POP, CLR_OVF,
      output UART_OEN, POP_DATA, FIFO_COUNT, EMPTY, FULL, OVERFLOW, IRQ
   );

   modport master (
      output UART_DATA, UART_RXRDY, POP, CLR_OVF,
      input  UART_OEN, POP_DATA, FIFO_COUNT, EMPTY, FULL, OVERFLOW, IRQ
   );
endinterface

// File: rtl/uart_rx_byte_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_buffer
// Drains received bytes from CoreUART (RXRDY / active-low OEN handshake) into a
// DEPTH-entry first-word-fall-through FIFO and raises a level IRQ when the
// fill level reaches THRESH or when data has sat unread for TIMEOUT_CYC cycles.
// Ports:
//   HCLK     - system clock
//   HRESETN  - asynchronous active-low reset
//   bus      - uart_rx_byte_buffer_if.slave (UART handshake + CPU read side)
// ---------------------------------------------------------------------------
module uart_rx_byte_buffer #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int THRESH      = 8,
   parameter int TIMEOUT_CYC = 4000
) (
   input  logic                   HCLK,
   input  logic                   HRESETN,
   uart_rx_byte_buffer_if.slave   bus
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   THRESH_CNT = (ADDR_W+1)'(THRESH);
   localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
   localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]  TMO_ONE    = TMO_W'(1);

   logic [1:0]        state_reg, state_next;
   logic              oen_reg;
   logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              ovf_reg;
   logic              irq_reg;
   logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;

   logic [7:0]        mem [DEPTH];

   logic              empty, full, wr_en, pop_valid;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == DEPTH_CNT);
   // The byte is stored during the single ACK cycle; entry to ACK already
   // required a free slot, so no fullness check is needed here.
   assign wr_en     = (state_reg == ST_ACK);
   assign pop_valid = bus.POP & ~empty;

   // Capture FSM: WAIT holds off until the UART drops RXRDY so the same byte
   // is never captured twice.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.UART_RXRDY && !full) state_next = ST_ACK;
         ST_ACK:  state_next = ST_WAIT;
         ST_WAIT: if (!bus.UART_RXRDY) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      case ({wr_en, pop_valid})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   // Idle timer: counts cycles of unchanged, non-empty FIFO; saturates.
   always_comb begin
      tmo_cnt_next = tmo_cnt_reg;
      if (wr_en || pop_valid || empty)
         tmo_cnt_next = '0;
      else if (tmo_cnt_reg != TMO_MAX)
         tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
   end

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_reg   <= ST_IDLE;
         oen_reg     <= 1'b1;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         ovf_reg     <= 1'b0;
         irq_reg     <= 1'b0;
         tmo_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         // OEN is low exactly while the FSM sits in ACK.
         oen_reg     <= (state_next != ST_ACK);
         count_reg   <= count_next;
         tmo_cnt_reg <= tmo_cnt_next;
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_valid)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         // A byte waiting while full means the UART may overrun; setting wins
         // over a simultaneous clear so the event is never missed.
         if ((state_reg == ST_IDLE) && bus.UART_RXRDY && full)
            ovf_reg <= 1'b1;
         else if (bus.CLR_OVF)
            ovf_reg <= 1'b0;
         irq_reg <= (count_next >= THRESH_CNT) | (tmo_cnt_next == TMO_MAX);
      end
   end

   // Storage is not reset; contents are only visible while the FIFO is non-empty.
   always_ff @(posedge HCLK) begin
      if (wr_en)
         mem[wr_ptr_reg] <= bus.UART_DATA;
   end

   assign bus.UART_OEN   = oen_reg;
   assign bus.FIFO_COUNT = count_reg;
   assign bus.EMPTY      = empty;
   assign bus.FULL       = full;
   assign bus.OVERFLOW   = ovf_reg;
   assign bus.IRQ        = irq_reg;
   // First-word-fall-through read; forced to zero when there is no head byte.
   assign bus.POP_DATA   = empty ? 8'h00 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte_buffer
// Self-checking bench: a simple CoreUART model feeds bytes, a queue-based
// scoreboard tracks what the FIFO must hold, and each scenario task adds its
// own directed checks on top of the per-cycle scoreboard.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte_buffer;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int THRESH = 8;
   localparam int TMO    = 4000;

   logic HCLK = 1'b0;
   logic HRESETN = 1'b0;

   always #5 HCLK = ~HCLK;

   uart_rx_byte_buffer_if #(.ADDR_W(ADDR_W)) bus_if ();

   uart_rx_byte_buffer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .THRESH(THRESH), .TIMEOUT_CYC(TMO)
   ) dut (
      .HCLK(HCLK),
      .HRESETN(HRESETN),
      .bus(bus_if.slave)
   );

   // Reference model state
   logic [7:0] q[$];        // bytes the FIFO must hold, head first
   logic [7:0] src[$];      // bytes the UART model still has to deliver
   logic [7:0] popped[$];   // bytes consumed, in order
   int  idle_m;             // cycles the non-empty FIFO has been untouched
   bit  ovf_m;
   int  gap;                // extra cycles the UART keeps RXRDY low
   bit  rand_gap;
   int  n_both, n_empty_pop;

   int  n_checks, n_errors;

   // One clock cycle: apply POP/CLR_OVF, advance the model, compare all outputs.
   task automatic tick(input bit pop, input bit clr);
      bit ack, pv, set_ovf;
      logic [7:0] ack_byte;
      int sz_before;
      logic [7:0] exp_data;
      bit exp_irq;
      ack       = (bus_if.UART_OEN === 1'b0);
      ack_byte  = bus_if.UART_DATA;
      sz_before = q.size();
      pv        = pop && (sz_before > 0);
      set_ovf   = (bus_if.UART_RXRDY === 1'b1) && (sz_before == DEPTH);
      if (ack && pv) n_both++;
      if (pop && sz_before == 0) n_empty_pop++;
      bus_if.POP     = pop;
      bus_if.CLR_OVF = clr;
      @(posedge HCLK);
      #1;
      bus_if.POP     = 1'b0;
      bus_if.CLR_OVF = 1'b0;

      if (pv) begin
         popped.push_back(q[0]);
         $display("[%0t] pop     0x%02h", $time, q[0]);
         void'(q.pop_front());
      end
      if (ack) begin
         q.push_back(ack_byte);
         $display("[%0t] capture 0x%02h count=%0d", $time, ack_byte, q.size());
      end
      if (ack || pv || sz_before == 0) idle_m = 0;
      else if (idle_m < TMO) idle_m++;
      if (set_ovf) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;

      // UART model: drop RXRDY once acknowledged, then offer the next byte.
      if (ack) begin
         bus_if.UART_RXRDY = 1'b0;
         gap = rand_gap ? int'($urandom_range(0, 3)) : 0;
      end else if (bus_if.UART_RXRDY !== 1'b1) begin
         if (gap > 0) gap--;
         else if (src.size() > 0) begin
            bus_if.UART_DATA  = src.pop_front();
            bus_if.UART_RXRDY = 1'b1;
         end
      end

      exp_data = (q.size() == 0) ? 8'h00 : q[0];
      exp_irq  = (q.size() >= THRESH) || (idle_m >= TMO);

      n_checks++;
      if (bus_if.FIFO_COUNT !== (ADDR_W+1)'(q.size())) begin
         n_errors++;
         $display("FAIL sb_count: got %0d expected %0d", bus_if.FIFO_COUNT, q.size());
      end
      n_checks++;
      if (bus_if.EMPTY !== (q.size() == 0)) begin
         n_errors++;
         $display("FAIL sb_empty: got %b expected %b", bus_if.EMPTY, q.size() == 0);
      end
      n_checks++;
      if (bus_if.FULL !== (q.size() == DEPTH)) begin
         n_errors++;
         $display("FAIL sb_full: got %b expected %b", bus_if.FULL, q.size() == DEPTH);
      end
      n_checks++;
      if (bus_if.POP_DATA !== exp_data) begin
         n_errors++;
         $display("FAIL sb_pop_data: got 0x%02h expected 0x%02h", bus_if.POP_DATA, exp_data);
      end
      n_checks++;
      if (bus_if.IRQ !== exp_irq) begin
         n_errors++;
         $display("FAIL sb_irq: got %b expected %b (count=%0d idle=%0d)",
                  bus_if.IRQ, exp_irq, q.size(), idle_m);
      end
      n_checks++;
      if (bus_if.OVERFLOW !== ovf_m) begin
         n_errors++;
         $display("FAIL sb_overflow: got %b expected %b", bus_if.OVERFLOW, ovf_m);
      end
      n_checks++;
      if (ack && bus_if.UART_OEN === 1'b0) begin
         n_errors++;
         $display("FAIL sb_oen_pulse: OEN low for 2 consecutive cycles, required 1");
      end
   endtask

   task automatic test_reset();
      bus_if.UART_DATA  = 8'h00;
      bus_if.UART_RXRDY = 1'b0;
      bus_if.POP        = 1'b0;
      bus_if.CLR_OVF    = 1'b0;
      HRESETN = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      n_checks++;
      if (bus_if.UART_OEN !== 1'b1 || bus_if.FIFO_COUNT !== '0 || bus_if.EMPTY !== 1'b1 ||
          bus_if.FULL !== 1'b0 || bus_if.OVERFLOW !== 1'b0 || bus_if.IRQ !== 1'b0 ||
          bus_if.POP_DATA !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_values: oen=%b cnt=%0d empty=%b full=%b ovf=%b irq=%b data=%02h required 1,0,1,0,0,0,00",
                  bus_if.UART_OEN, bus_if.FIFO_COUNT, bus_if.EMPTY, bus_if.FULL,
                  bus_if.OVERFLOW, bus_if.IRQ, bus_if.POP_DATA);
      end
      @(negedge HCLK);
      HRESETN = 1'b1;
      q.delete(); src.delete(); popped.delete();
      idle_m = 0; ovf_m = 1'b0; gap = 0; rand_gap = 1'b0;
      repeat (2) tick(1'b0, 1'b0);
   endtask

   task automatic test_single_byte();
      bit seen;
      seen = 1'b0;
      src.push_back(8'hA5);
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1'b0, 1'b0);
         if (bus_if.UART_OEN === 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL single_oen: OEN never went low within 20 cycles");
      end
      tick(1'b0, 1'b0);
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd1 || bus_if.EMPTY !== 1'b0 || bus_if.POP_DATA !== 8'hA5) begin
         n_errors++;
         $display("FAIL single_capture: cnt=%0d empty=%b data=%02h required 1,0,A5",
                  bus_if.FIFO_COUNT, bus_if.EMPTY, bus_if.POP_DATA);
      end
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd0 || bus_if.EMPTY !== 1'b1 || bus_if.IRQ !== 1'b0) begin
         n_errors++;
         $display("FAIL single_pop: cnt=%0d empty=%b irq=%b required 0,1,0",
                  bus_if.FIFO_COUNT, bus_if.EMPTY, bus_if.IRQ);
      end
   endtask

   task automatic test_threshold();
      int i;
      for (int b = 0; b < 8; b++) src.push_back(8'(b));
      i = 0;
      while (q.size() < 8 && i < 100) begin
         tick(1'b0, 1'b0);
         i++;
      end
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd8 || bus_if.IRQ !== 1'b1) begin
         n_errors++;
         $display("FAIL thresh_reach: cnt=%0d irq=%b required 8,1", bus_if.FIFO_COUNT, bus_if.IRQ);
      end
      tick(1'b1, 1'b0);
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd7 || bus_if.IRQ !== 1'b0) begin
         n_errors++;
         $display("FAIL thresh_drop: cnt=%0d irq=%b required 7,0", bus_if.FIFO_COUNT, bus_if.IRQ);
      end
      for (int k = 1; k < 8; k++) begin
         n_checks++;
         if (bus_if.POP_DATA !== 8'(k)) begin
            n_errors++;
            $display("FAIL thresh_order: got %02h required %02h", bus_if.POP_DATA, 8'(k));
         end
         tick(1'b1, 1'b0);
      end
   endtask

   task automatic test_full_overflow();
      int i;
      for (int b = 0; b < 17; b++) src.push_back(8'h40 + 8'(b));
      i = 0;
      while (q.size() < DEPTH && i < 200) begin
         tick(1'b0, 1'b0);
         i++;
      end
      repeat (4) tick(1'b0, 1'b0);
      n_checks++;
      if (bus_if.FULL !== 1'b1 || bus_if.UART_OEN !== 1'b1 || bus_if.OVERFLOW !== 1'b1 ||
          bus_if.FIFO_COUNT !== 5'd16) begin
         n_errors++;
         $display("FAIL full_ovf: full=%b oen=%b ovf=%b cnt=%0d required 1,1,1,16",
                  bus_if.FULL, bus_if.UART_OEN, bus_if.OVERFLOW, bus_if.FIFO_COUNT);
      end
      tick(1'b1, 1'b0);
      i = 0;
      while (q.size() < DEPTH && i < 20) begin
         tick(1'b0, 1'b0);
         i++;
      end
      tick(1'b0, 1'b0);
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd16 || bus_if.POP_DATA !== 8'h41) begin
         n_errors++;
         $display("FAIL full_byte17: cnt=%0d head=%02h required 16,41",
                  bus_if.FIFO_COUNT, bus_if.POP_DATA);
      end
      tick(1'b0, 1'b1);
      n_checks++;
      if (bus_if.OVERFLOW !== 1'b0) begin
         n_errors++;
         $display("FAIL full_clr_ovf: ovf=%b required 0", bus_if.OVERFLOW);
      end
      for (int k = 1; k < 17; k++) begin
         n_checks++;
         if (bus_if.POP_DATA !== 8'h40 + 8'(k)) begin
            n_errors++;
            $display("FAIL full_order: got %02h required %02h", bus_if.POP_DATA, 8'h40 + 8'(k));
         end
         tick(1'b1, 1'b0);
      end
   endtask

   task automatic test_timeout();
      int i, k;
      src.push_back(8'h3C);
      i = 0;
      while (q.size() < 1 && i < 20) begin
         tick(1'b0, 1'b0);
         i++;
      end
      n_checks++;
      if (bus_if.IRQ !== 1'b0) begin
         n_errors++;
         $display("FAIL tmo_start: irq=%b required 0", bus_if.IRQ);
      end
      k = 0;
      while (bus_if.IRQ !== 1'b1 && k < TMO + 20) begin
         tick(1'b0, 1'b0);
         k++;
      end
      n_checks++;
      if (k != TMO) begin
         n_errors++;
         $display("FAIL tmo_latency: irq rose %0d cycles after write, required %0d", k, TMO);
      end
      tick(1'b1, 1'b0);
      n_checks++;
      if (bus_if.IRQ !== 1'b0 || bus_if.EMPTY !== 1'b1) begin
         n_errors++;
         $display("FAIL tmo_pop: irq=%b empty=%b required 0,1", bus_if.IRQ, bus_if.EMPTY);
      end
   endtask

   task automatic test_wrap_concurrency();
      logic [7:0] sent[$];
      int base, i;
      bit mism;
      rand_gap = 1'b1;
      base = popped.size();
      for (int b = 0; b < 40; b++) begin
         sent.push_back(8'($urandom));
         src.push_back(sent[b]);
      end
      i = 0;
      while (popped.size() - base < 40 && i < 3000) begin
         tick(bit'($urandom_range(0, 1)), 1'b0);
         i++;
      end
      n_checks++;
      if (popped.size() - base != 40) begin
         n_errors++;
         $display("FAIL wrap_drain: drained %0d bytes, required 40", popped.size() - base);
      end
      mism = 1'b0;
      for (int b = 0; b < 40 && b + base < popped.size(); b++)
         if (popped[b + base] !== sent[b]) mism = 1'b1;
      n_checks++;
      if (mism) begin
         n_errors++;
         $display("FAIL wrap_order: popped sequence differs from sent sequence");
      end
      $display("[%0t] wrap: same-cycle ack+pop=%0d, pops while empty=%0d", $time, n_both, n_empty_pop);
      rand_gap = 1'b0;
   endtask

   task automatic test_reset_mid_capture();
      int i;
      for (int b = 0; b < 6; b++) src.push_back(8'h90 + 8'(b));
      i = 0;
      while (!(q.size() == 5 && bus_if.UART_OEN === 1'b0) && i < 100) begin
         tick(1'b0, 1'b0);
         i++;
      end
      n_checks++;
      if (i >= 100) begin
         n_errors++;
         $display("FAIL rst_reach_ack: count=%0d oen=%b, required 5,0", q.size(), bus_if.UART_OEN);
      end
      HRESETN = 1'b0;
      #1;
      n_checks++;
      if (bus_if.UART_OEN !== 1'b1 || bus_if.FIFO_COUNT !== '0 || bus_if.EMPTY !== 1'b1 ||
          bus_if.FULL !== 1'b0 || bus_if.OVERFLOW !== 1'b0 || bus_if.IRQ !== 1'b0 ||
          bus_if.POP_DATA !== 8'h00) begin
         n_errors++;
         $display("FAIL rst_async: oen=%b cnt=%0d empty=%b full=%b ovf=%b irq=%b data=%02h required 1,0,1,0,0,0,00",
                  bus_if.UART_OEN, bus_if.FIFO_COUNT, bus_if.EMPTY, bus_if.FULL,
                  bus_if.OVERFLOW, bus_if.IRQ, bus_if.POP_DATA);
      end
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETN = 1'b1;
      q.delete();
      idle_m = 0;
      ovf_m  = 1'b0;
      i = 0;
      while (q.size() < 1 && i < 20) begin
         tick(1'b0, 1'b0);
         i++;
      end
      n_checks++;
      if (bus_if.FIFO_COUNT !== 5'd1 || bus_if.POP_DATA !== 8'h95) begin
         n_errors++;
         $display("FAIL rst_recapture: cnt=%0d data=%02h required 1,95",
                  bus_if.FIFO_COUNT, bus_if.POP_DATA);
      end
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n_checks++;
      if (bus_if.EMPTY !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_drain: empty=%b required 1", bus_if.EMPTY);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_both = 0;
      n_empty_pop = 0;
      test_reset();
      test_single_byte();
      test_threshold();
      test_full_overflow();
      test_timeout();
      test_wrap_concurrency();
      test_reset_mid_capture();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
